// File: rtl/thor2024_regfile_wrarb.sv
// thor2024_regfile_wrarb: round-robin shared write port for the register-file RAM with zero-fill sweep.
// Optional macro THOR2024_WRARB_R0_PROTECT_EN: suppresses RUN-mode writes to address 0 so register 0 stays zero.
module thor2024_regfile_wrarb #(
    parameter  int WID  = 64,
    parameter  int DEP  = 256,
    parameter  int NREQ = 3,
    localparam int AW   = $clog2(DEP),
    localparam int BW   = WID / 8,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_req,
    output logic                busy,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*WID-1:0] req_data,
    input  logic [NREQ*BW-1:0]  req_be,
    output logic                ram_ena,
    output logic [BW-1:0]       ram_wea,
    output logic [AW-1:0]       ram_addra,
    output logic [WID-1:0]      ram_dina
);

`ifdef THOR2024_WRARB_R0_PROTECT_EN
    localparam bit R0P = 1'b1;
`else
    localparam bit R0P = 1'b0;
`endif

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  clr_addr_q, clr_addr_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           ena_q, ena_d;
    logic [BW-1:0]  wea_q, wea_d;
    logic [AW-1:0]  addra_q, addra_d;
    logic [WID-1:0] dina_q, dina_d;

    logic [NREQ-1:0] rot;
    logic            any;
    logic [PW-1:0]   off;
    logic [PW:0]     sum;
    logic [PW-1:0]   win;
    logic            gnt;
    logic            wr_en;
    logic [AW-1:0]   g_addr;
    logic [WID-1:0]  g_data;
    logic [BW-1:0]   g_be;

    // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot = NREQ'({req_valid, req_valid} >> rr_ptr_q);
        any = 1'b0;
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                off = PW'(k);
            end
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        win = sum >= (PW + 1)'(NREQ) ? PW'(sum - (PW + 1)'(NREQ)) : PW'(sum);
        gnt = state_q == RUN && !clear_req && any;
        req_ready = gnt ? NREQ'(1) << win : '0;
        g_addr = req_addr[int'(win) * AW +: AW];
        g_data = req_data[int'(win) * WID +: WID];
        g_be = req_be[int'(win) * BW +: BW];
        wr_en = gnt && !(R0P && g_addr == '0);
    end

    // Next state and next registered RAM-port values for the sweep and run modes.
    always_comb begin
        state_d = state_q;
        clr_addr_d = clr_addr_q;
        rr_ptr_d = rr_ptr_q;
        ena_d = 1'b0;
        wea_d = '0;
        addra_d = addra_q;
        dina_d = dina_q;
        if (state_q == CLEAR) begin
            ena_d = 1'b1;
            wea_d = '1;
            addra_d = clr_addr_q;
            dina_d = '0;
            clr_addr_d = clr_addr_q + 1'b1;
            state_d = clr_addr_q == AW'(DEP - 1) ? RUN : CLEAR;
        end else if (clear_req) begin
            state_d = CLEAR;
            clr_addr_d = '0;
        end else if (gnt) begin
            rr_ptr_d = win == PW'(NREQ - 1) ? '0 : win + 1'b1;
            ena_d = wr_en;
            wea_d = wr_en ? g_be : '0;
            addra_d = wr_en ? g_addr : addra_q;
            dina_d = wr_en ? g_data : dina_q;
        end
    end

    // State and RAM-port registers; reset restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            clr_addr_q <= '0;
            rr_ptr_q <= '0;
            ena_q <= 1'b0;
            wea_q <= '0;
            addra_q <= '0;
            dina_q <= '0;
        end else begin
            state_q <= state_d;
            clr_addr_q <= clr_addr_d;
            rr_ptr_q <= rr_ptr_d;
            ena_q <= ena_d;
            wea_q <= wea_d;
            addra_q <= addra_d;
            dina_q <= dina_d;
        end
    end

    assign busy = state_q == CLEAR;
    assign ram_ena = ena_q;
    assign ram_wea = wea_q;
    assign ram_addra = addra_q;
    assign ram_dina = dina_q;

endmodule

// File: tb/tb_thor2024_regfile_wrarb.sv
// tb_thor2024_regfile_wrarb: scoreboard bench for the register-file write arbiter.
module tb_thor2024_regfile_wrarb;

`ifdef THOR2024_WRARB_R0_PROTECT_EN
    localparam bit R0P = 1'b1;
`else
    localparam bit R0P = 1'b0;
`endif

    typedef struct {
        logic        ena;
        logic [7:0]  be;
        logic [7:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        clear_req;
    logic        busy;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [23:0] req_addr;
    logic [191:0] req_data;
    logic [23:0] req_be;
    logic        ram_ena;
    logic [7:0]  ram_wea;
    logic [7:0]  ram_addra;
    logic [63:0] ram_dina;

    logic [7:0]  ra [3];
    logic [63:0] rd [3];
    logic [7:0]  rb [3];
    logic [63:0] mem [256];

    wr_t sbq [$];
    int  rr;
    int  n_vec;
    int  n_bad;

    assign req_addr = {ra[2], ra[1], ra[0]};
    assign req_data = {rd[2], rd[1], rd[0]};
    assign req_be = {rb[2], rb[1], rb[0]};

    thor2024_regfile_wrarb dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear_req(clear_req),
        .busy(busy),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_be(req_be),
        .ram_ena(ram_ena),
        .ram_wea(ram_wea),
        .ram_addra(ram_addra),
        .ram_dina(ram_dina)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-writable RAM model fed by the DUT write port.
    always @(posedge clk) begin
        if (ram_ena)
            for (int b = 0; b < 8; b++)
                if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [63:0] d, input logic [7:0] b);
        ra[i] = a;
        rd[i] = d;
        rb[i] = b;
    endtask

    // One RUN-mode cycle: called at negedge, checks last cycle's write and this cycle's grant.
    task automatic run_cycle(input logic [2:0] v, input logic clr);
        wr_t e;
        logic [2:0] exp_rdy;
        int gi;
        req_valid = v;
        clear_req = clr;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.ena) check("wr", {ram_ena, ram_wea, ram_addra, ram_dina}, {1'b1, e.be, e.addr, e.data});
            else check("idle", {ram_ena, ram_wea}, 9'h0);
        end
        exp_rdy = '0;
        gi = -1;
        if (!clr)
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (rr + k) % 3;
                if (gi < 0 && v[i]) gi = i;
            end
        if (gi >= 0) begin
            exp_rdy[gi] = 1'b1;
            rr = (gi + 1) % 3;
            e.ena = !(R0P && ra[gi] == 8'h00);
            e.be = rb[gi];
            e.addr = ra[gi];
            e.data = rd[gi];
            sbq.push_back(e);
        end else if (!clr) begin
            e.ena = 1'b0;
            e.be = '0;
            e.addr = '0;
            e.data = '0;
            sbq.push_back(e);
        end
        check("ready", req_ready, exp_rdy);
        @(negedge clk);
    endtask

    // Called at negedge with busy just raised; follows the full zero-fill sweep.
    task automatic sweep_check();
        int a;
        int busy_n;
        int rdy_bad;
        a = 0;
        busy_n = 0;
        rdy_bad = 0;
        sbq.delete();
        #1;
        check("sw_start", {busy, ram_ena}, 2'b10);
        if (busy) busy_n = 1;
        for (int c = 0; c < 300 && busy; c++) begin
            @(posedge clk);
            #1;
            check("sw_wr", {ram_ena, ram_wea, ram_addra, ram_dina}, {1'b1, 8'hFF, 8'(a), 64'h0});
            a++;
            if (busy) begin
                busy_n++;
                if (req_ready != 3'b000) rdy_bad++;
            end
        end
        check("sw_busy_cycles", busy_n, 256);
        check("sw_writes", a, 256);
        check("sw_ready", rdy_bad, 0);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rr = 0;
        for (int i = 0; i < 256; i++) mem[i] = 64'hA5A5_A5A5_A5A5_A5A5;
        for (int i = 0; i < 3; i++) set_req(i, 8'h00, 64'h0, 8'h00);
        rst_n = 1'b0;
        clear_req = 1'b0;
        req_valid = 3'b000;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_port", {ram_ena, ram_wea, ram_addra, ram_dina}, 81'h0);
        check("rst_busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check();
        run_cycle(3'b000, 1'b0);
        run_cycle(3'b000, 1'b0);

        set_req(0, 8'h01, 64'h1111_2222_3333_4444, 8'hFF);
        set_req(1, 8'h02, 64'h5555_6666_7777_8888, 8'h3C);
        set_req(2, 8'h03, 64'h9999_AAAA_BBBB_CCCC, 8'h81);
        for (int i = 0; i < 6; i++) run_cycle(3'b111, 1'b0);
        run_cycle(3'b000, 1'b0);

        set_req(2, 8'h10, 64'hDEAD_BEEF_0123_4567, 8'h0F);
        run_cycle(3'b100, 1'b0);
        run_cycle(3'b000, 1'b0);
        run_cycle(3'b000, 1'b0);
        check("rd_10", mem[8'h10], 64'h0000_0000_0123_4567);

        set_req(1, 8'h05, 64'hFFFF_0000_FFFF_0000, 8'h00);
        run_cycle(3'b010, 1'b0);
        run_cycle(3'b000, 1'b0);
        check("rd_05", mem[8'h05], 64'h0);

        set_req(0, 8'h20, 64'h0102_0304_0506_0708, 8'hF0);
        set_req(1, 8'h21, 64'h1112_1314_1516_1718, 8'hFF);
        run_cycle(3'b011, 1'b0);
        run_cycle(3'b011, 1'b1);
        clear_req = 1'b0;
        sweep_check();
        run_cycle(3'b011, 1'b0);
        run_cycle(3'b000, 1'b0);
        run_cycle(3'b000, 1'b0);

        rst_n = 1'b0;
        clear_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        clear_req = 1'b0;
        rr = 0;
        for (int c = 0; c < 300 && !(ram_ena && ram_addra == 8'd100); c++) begin
            @(posedge clk);
            #1;
        end
        check("reach100", {ram_ena, ram_addra}, {1'b1, 8'd100});
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check();
        check("rd_sweep_10", mem[8'h10], 64'h0);

        set_req(0, 8'h00, 64'h1, 8'hFF);
        run_cycle(3'b001, 1'b0);
        run_cycle(3'b000, 1'b0);
        run_cycle(3'b000, 1'b0);
        check("rd_r0", mem[0], R0P ? 64'h0 : 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/thor2024_regfile_wrarb.md
Name: thor2024_regfile_wrarb

Overview:
Write-port controller for the byte-writable, simple-dual-port register-file RAM. Shares the RAM's single write port among NREQ requesters (e.g. two ALU commit slots plus load writeback) using round-robin arbitration. Drives the RAM write port from registered outputs. Runs a zero-fill sweep of the whole RAM after reset, or on demand, so contents are defined without relying on RAM initialisation.

Parameters:
WID, 64, data width in bits; must be a multiple of 8.
DEP, 256, RAM depth in words; power of two.
NREQ, 3, number of write requesters; range 2..8.
AW, $clog2(DEP), address width (local, derived).

Ports:
clk  in  1  sole clock; same clock drives RAM port A.
rst_n  in  1  synchronous reset, active low.
clear_req  in  1  pulse; starts a zero-fill sweep.
busy  out  1  high while a sweep is in progress.
req_valid  in  NREQ  per-requester write request.
req_ready  out  NREQ  per-requester grant (one-hot or zero).
req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
req_data  in  NREQ*WID  flattened write data.
req_be  in  NREQ*WID/8  flattened byte enables.
ram_ena  out  1  RAM port A enable.
ram_wea  out  WID/8  RAM byte write enables.
ram_addra  out  AW  RAM write address.
ram_dina  out  WID  RAM write data.

Behaviour:
- Reset (rst_n low at posedge):
  - State -> CLEAR; clr_addr=0; rr_ptr=0.
  - ram_ena=0, ram_wea=0, ram_addra=0, ram_dina=0.
  - busy=1 from the first cycle after reset.
- States: CLEAR, RUN.
- CLEAR:
  - Each cycle registers ram_ena=1, ram_wea=all ones, ram_addra=clr_addr, ram_dina=0; then clr_addr increments.
  - When clr_addr==DEP-1 has been issued, go to RUN and clear busy; exactly DEP writes are issued.
  - req_ready=0 throughout; clear_req is ignored.
- RUN, arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - req_ready[winner]=1; all other bits 0. A transfer is valid && ready in the same cycle.
  - After a grant, rr_ptr = winner+1 mod NREQ. With no grant, rr_ptr holds.
- RUN, output (registered, latency 1):
  - On a grant, the next cycle shows ram_ena=1, ram_wea=req_be[winner], ram_addra/ram_dina from the winner.
  - A grant with req_be=0 still asserts ram_ena with wea=0.
  - With no grant, ram_ena=0 and ram_wea=0; addra and dina hold their previous values.
- Back-to-back grants give one RAM write per cycle. Ungranted requesters must hold valid, addr, data and be stable until granted.
- clear_req in RUN:
  - No grant that cycle; req_ready=0.
  - The write registered in the previous cycle completes normally.
  - Next state CLEAR with clr_addr=0; busy rises the next cycle.
- clear_req coincident with reset: reset dominates (the sweep starts anyway).
- Reset mid-sweep or mid-write: the sweep restarts from address 0. A partially written word is not protected, because the sweep rewrites it.
- Write ordering: successive writes to the same address are presented in grant order; the later grant wins in RAM.

Optional Feature:
THOR2024_WRARB_R0_PROTECT_EN:
- Defined: in RUN, a granted request to address 0 is acknowledged (req_ready=1, rr_ptr advances), but the RAM write is suppressed (ram_ena=0, ram_wea=0), keeping register 0 hard zero. The CLEAR sweep still writes address 0.
- Undefined: address 0 is written like any other address.

Test Plan:
- Reset low 2 cycles, then high -> busy=1 for exactly 256 cycles; ram_addra runs 0..255 with wea=8'hFF and dina=0; afterwards busy=0 and ram_ena=0.
- In RUN, req_valid=3'b111 held for 6 cycles -> grants in order 0,1,2,0,1,2. Each write appears on the RAM port one cycle after its grant, with the matching addr, data and be.
- Only requester 2 valid (addr=8'h10, data=64'hDEAD_BEEF_0123_4567, be=8'h0F), with rr_ptr=0 -> granted in the same cycle; next cycle ram_wea=8'h0F, ram_addra=8'h10. A read of 8'h10 after the write shows 64'h0000_0000_0123_4567.
- clear_req pulsed while req_valid=3'b011 -> req_ready=0 that cycle; the prior registered write still appears; busy=1 for 256 cycles; then arbitration resumes from the retained rr_ptr.
- rst_n asserted at sweep address 100 -> next sweep write is address 0, and the full 256-write sweep is repeated.
- With THOR2024_WRARB_R0_PROTECT_EN defined, requester 0 writes addr 0 with data 64'h1 -> req_ready=1, ram_ena stays 0, and a readback of address 0 returns 0. Without the macro, readback returns 64'h1.
